rtc_bus_driver: RTL and testbench

- Downstream bus stage for the RTC controller.
- Consumes the address/data byte produced by the initialization, write and read state machines.
- Generates the multiplexed address/data parallel bus cycle to the external RTC chip: chip select, address/data select, read and write strobes, tri-state control, and read-data capture.
- Single-transaction handshake (request / busy / done) toward the upstream machines.

---
 rtl/rtc_bus_driver.sv | 243 ++++++++++++++++++++++++
 tb/tb_rtc_bus_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_driver.sv
// -----------------------------------------------------------------------------
// rtc_bus_driver
//
// Downstream bus stage of the RTC controller. Takes one address/data byte
// request at a time from the upstream init/write/read machines. It runs the
// multiplexed address/data parallel bus cycle toward the external RTC chip.
//
// Bus cycle, one phase per state. Each phase lasts its parameter count:
//   A_SET -> A_STB -> A_HLD -> D_SET -> D_STB -> D_HLD -> RECOV -> IDLE
// The address is always latched into the RTC with wr_n, including reads.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   req_write  start a write (sampled only when idle; write wins over read)
//   req_read   start a read  (sampled only when idle)
//   addr_in    RTC register address, latched on accept
//   wdata_in   write data, latched on accept
//   rdata_out  last byte read from the RTC
//   busy       transaction in progress
//   done       one-cycle pulse in the first idle cycle after recovery
//   ad_out     value driven onto the AD bus
//   ad_in      value returned on the AD bus
//   ad_oe      1 = FPGA drives the AD bus
//   cs_n       chip select, active low
//   ad_sel     0 = address phase, 1 = data phase
//   wr_n       write strobe, active low
//   rd_n       read strobe, active low
// -----------------------------------------------------------------------------
module rtc_bus_driver #(
    parameter int T_SETUP   = 2,
    parameter int T_STROBE  = 4,
    parameter int T_HOLD    = 2,
    parameter int T_RECOVER = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_write,
    input  logic       req_read,
    input  logic [7:0] addr_in,
    input  logic [7:0] wdata_in,
    output logic [7:0] rdata_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] ad_out,
    input  logic [7:0] ad_in,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_sel,
    output logic       wr_n,
    output logic       rd_n
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A_SET = 3'd1,
        ST_A_STB = 3'd2,
        ST_A_HLD = 3'd3,
        ST_D_SET = 3'd4,
        ST_D_STB = 3'd5,
        ST_D_HLD = 3'd6,
        ST_RECOV = 3'd7
    } state_t;

    // The counter counts down to zero, so each phase loads its length minus one.
    localparam logic [7:0] LOAD_SETUP   = 8'(T_SETUP - 1);
    localparam logic [7:0] LOAD_STROBE  = 8'(T_STROBE - 1);
    localparam logic [7:0] LOAD_HOLD    = 8'(T_HOLD - 1);
    localparam logic [7:0] LOAD_RECOVER = 8'(T_RECOVER - 1);

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic       op_write_r;
    logic [7:0] addr_r;
    logic [7:0] wdata_r;
    logic       accept_s;

    // Values the output decode uses. On the accepting edge these are the fresh request inputs.
    logic       op_write_s;
    logic [7:0] addr_s;
    logic [7:0] wdata_s;

    // Next-cycle bus values, registered into the output ports.
    logic       cs_n_s;
    logic       ad_sel_s;
    logic       wr_n_s;
    logic       rd_n_s;
    logic       ad_oe_s;
    logic [7:0] ad_out_s;

    function automatic logic [7:0] phase_load(input state_t st);
        logic [7:0] ld;
        case (st)
            ST_A_SET, ST_D_SET: ld = LOAD_SETUP;
            ST_A_STB, ST_D_STB: ld = LOAD_STROBE;
            ST_A_HLD, ST_D_HLD: ld = LOAD_HOLD;
            ST_RECOV:           ld = LOAD_RECOVER;
            default:            ld = 8'd0;
        endcase
        return ld;
    endfunction

    assign accept_s   = (state_r == ST_IDLE) && (req_write || req_read);
    assign op_write_s = accept_s ? req_write : op_write_r;
    assign addr_s     = accept_s ? addr_in   : addr_r;
    assign wdata_s    = accept_s ? wdata_in  : wdata_r;

    // State register, phase counter and request latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            op_write_r <= 1'b0;
            addr_r     <= 8'h00;
            wdata_r    <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            op_write_r <= op_write_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
        end
    end

    // Next-state decode: each non-idle phase advances when its counter reaches zero.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_A_SET;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_A_SET: state_next_s = (cnt_r == 8'd0) ? ST_A_STB : ST_A_SET;
            ST_A_STB: state_next_s = (cnt_r == 8'd0) ? ST_A_HLD : ST_A_STB;
            ST_A_HLD: state_next_s = (cnt_r == 8'd0) ? ST_D_SET : ST_A_HLD;
            ST_D_SET: state_next_s = (cnt_r == 8'd0) ? ST_D_STB : ST_D_SET;
            ST_D_STB: state_next_s = (cnt_r == 8'd0) ? ST_D_HLD : ST_D_STB;
            ST_D_HLD: state_next_s = (cnt_r == 8'd0) ? ST_RECOV : ST_D_HLD;
            ST_RECOV: state_next_s = (cnt_r == 8'd0) ? ST_IDLE  : ST_RECOV;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Counter reloads on every state change, otherwise counts down (held at zero in idle).
    always_comb begin
        cnt_next_s = 8'd0;
        if (state_next_s != state_r) begin
            cnt_next_s = phase_load(state_next_s);
        end else if (state_r == ST_IDLE) begin
            cnt_next_s = 8'd0;
        end else begin
            cnt_next_s = cnt_r - 8'd1;
        end
    end

    // Output decode from the next state, so the registered pins line up with the state.
    always_comb begin
        cs_n_s   = 1'b1;
        ad_sel_s = 1'b1;
        wr_n_s   = 1'b1;
        rd_n_s   = 1'b1;
        ad_oe_s  = 1'b0;
        ad_out_s = 8'h00;
        case (state_next_s)
            ST_A_SET, ST_A_STB, ST_A_HLD: begin
                cs_n_s   = 1'b0;
                ad_sel_s = 1'b0;
                ad_oe_s  = 1'b1;
                ad_out_s = addr_s;
                if (state_next_s == ST_A_STB) begin
                    wr_n_s = 1'b0;
                end else begin
                    wr_n_s = 1'b1;
                end
            end
            ST_D_SET, ST_D_STB, ST_D_HLD: begin
                cs_n_s = 1'b0;
                if (op_write_s) begin
                    ad_oe_s  = 1'b1;
                    ad_out_s = wdata_s;
                    if (state_next_s == ST_D_STB) begin
                        wr_n_s = 1'b0;
                    end else begin
                        wr_n_s = 1'b1;
                    end
                end else begin
                    // Bus released to the RTC for the whole read data phase.
                    ad_oe_s  = 1'b0;
                    ad_out_s = 8'h00;
                    if (state_next_s == ST_D_STB) begin
                        rd_n_s = 1'b0;
                    end else begin
                        rd_n_s = 1'b1;
                    end
                end
            end
            default: begin
                cs_n_s   = 1'b1;
                ad_sel_s = 1'b1;
                ad_oe_s  = 1'b0;
                ad_out_s = 8'h00;
            end
        endcase
    end

    // Output registers for the bus pins and the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n   <= 1'b1;
            ad_sel <= 1'b1;
            wr_n   <= 1'b1;
            rd_n   <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            cs_n   <= cs_n_s;
            ad_sel <= ad_sel_s;
            wr_n   <= wr_n_s;
            rd_n   <= rd_n_s;
            ad_oe  <= ad_oe_s;
            ad_out <= ad_out_s;
            busy   <= (state_next_s != ST_IDLE);
            done   <= (state_r == ST_RECOV) && (state_next_s == ST_IDLE);
        end
    end

    // Read capture on the edge that ends the last read-strobe cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_out <= 8'h00;
        end else if ((state_r == ST_D_STB) && (cnt_r == 8'd0) && !op_write_r) begin
            rdata_out <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_driver.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_driver
//
// Directed bench for rtc_bus_driver with a per-cycle scoreboard. When a request
// is driven, the expected pin vector for every following cycle is pushed to a
// queue. The values come from the cycle windows of the bus protocol. Each clock
// pops one entry and compares it with the DUT pins sampled 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_rtc_bus_driver;

    localparam int TS = 2;
    localparam int TSTB = 4;
    localparam int TH = 2;
    localparam int TR = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_write;
    logic       req_read;
    logic [7:0] addr_in;
    logic [7:0] wdata_in;
    logic [7:0] rdata_out;
    logic       busy;
    logic       done;
    logic [7:0] ad_out;
    logic [7:0] ad_in;
    logic       ad_oe;
    logic       cs_n;
    logic       ad_sel;
    logic       wr_n;
    logic       rd_n;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int gap_cnt  = 0;
    bit gap_track = 1'b0;
    logic [7:0] rdata_model = 8'h00;

    logic [22:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    rtc_bus_driver #(
        .T_SETUP(TS), .T_STROBE(TSTB), .T_HOLD(TH), .T_RECOVER(TR)
    ) dut (
        .clk(clk), .reset(reset), .req_write(req_write), .req_read(req_read),
        .addr_in(addr_in), .wdata_in(wdata_in), .rdata_out(rdata_out),
        .busy(busy), .done(done), .ad_out(ad_out), .ad_in(ad_in),
        .ad_oe(ad_oe), .cs_n(cs_n), .ad_sel(ad_sel), .wr_n(wr_n), .rd_n(rd_n)
    );

    // Vector layout: {cs_n, ad_sel, wr_n, rd_n, ad_oe, ad_out, busy, done, rdata_out}
    function automatic logic [22:0] pack_vec(input logic cs, input logic sel, input logic wr,
                                             input logic rd, input logic oe, input logic [7:0] dout,
                                             input logic bsy, input logic dn, input logic [7:0] rdb);
        return {cs, sel, wr, rd, oe, dout, bsy, dn, rdb};
    endfunction

    function automatic logic [22:0] observed();
        return pack_vec(cs_n, ad_sel, wr_n, rd_n, ad_oe, ad_out, busy, done, rdata_out);
    endfunction

    task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Expected vectors for cycles 1..ncyc after the accepting edge.
    task automatic push_txn(input bit is_wr, input logic [7:0] a, input logic [7:0] w,
                            input logic [7:0] rd_byte, input int ncyc, input string tag);
        int p1 = TS;
        int p2 = TS + TSTB;
        int p3 = TS + TSTB + TH;
        int p4 = p3 + TS;
        int p5 = p4 + TSTB;
        int p6 = p5 + TH;
        int p7 = p6 + TR;
        bit addr_ph;
        bit data_ph;
        bit dstb;
        for (int k = 1; k <= ncyc; k++) begin
            addr_ph = (k <= p3);
            data_ph = (k > p3) && (k <= p6);
            dstb    = (k > p4) && (k <= p5);
            if (!is_wr && (k == p5 + 1)) rdata_model = rd_byte;
            exp_q.push_back(pack_vec(
                !(k <= p6),
                !addr_ph,
                !(((k > p1) && (k <= p2)) || (is_wr && dstb)),
                !(!is_wr && dstb),
                addr_ph || (is_wr && data_ph),
                addr_ph ? a : ((is_wr && data_ph) ? w : 8'h00),
                (k <= p7),
                (k == p7 + 1),
                rdata_model));
            tag_q.push_back($sformatf("%s_c%0d", tag, k));
        end
    endtask

    task automatic push_idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(pack_vec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, rdata_model));
            tag_q.push_back(tag);
        end
    endtask

    task automatic tick();
        logic [22:0] e;
        string t;
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        if (gap_track && cs_n === 1'b1 && busy === 1'b1) gap_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, observed(), e);
        end
    endtask

    initial begin
        reset = 1'b0; req_write = 1'b0; req_read = 1'b0;
        addr_in = 8'h00; wdata_in = 8'h00; ad_in = 8'h00;
        #12;
        check("reset_idle", observed(),
              pack_vec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        @(posedge clk); #1;
        reset = 1'b1;
        push_idle(2, "idle_after_reset");
        tick(); tick();

        // Plain write 0x45 to register 0x21
        addr_in = 8'h21; wdata_in = 8'h45; req_write = 1'b1;
        push_txn(1'b1, 8'h21, 8'h45, 8'h00, 21, "wr");
        tick();
        req_write = 1'b0;
        repeat (20) tick();
        push_idle(1, "wr_idle"); tick();

        // Read of register 0x33, RTC returns 0x5A
        ad_in = 8'h5A; addr_in = 8'h33; req_read = 1'b1;
        push_txn(1'b0, 8'h33, 8'h00, 8'h5A, 21, "rd");
        tick();
        req_read = 1'b0;
        repeat (20) tick();
        push_idle(1, "rd_idle"); tick();

        // Simultaneous requests: write wins, rdata untouched
        ad_in = 8'hEE; addr_in = 8'h10; wdata_in = 8'hA5;
        req_write = 1'b1; req_read = 1'b1;
        push_txn(1'b1, 8'h10, 8'hA5, 8'h00, 21, "both");
        tick();
        req_write = 1'b0; req_read = 1'b0;
        repeat (20) tick();
        push_idle(1, "both_idle"); tick();

        // Request pulsed in cycle 5 of a write is ignored
        done_cnt = 0;
        addr_in = 8'h44; wdata_in = 8'h99; req_write = 1'b1;
        push_txn(1'b1, 8'h44, 8'h99, 8'h00, 21, "ign");
        tick();
        req_write = 1'b0;
        repeat (4) tick();
        addr_in = 8'h77; req_read = 1'b1;
        tick();
        req_read = 1'b0;
        repeat (15) tick();
        push_idle(4, "ign_idle");
        repeat (4) tick();
        check_int("ign_done_count", done_cnt, 1);

        // Asynchronous reset in cycle 12 of a write
        addr_in = 8'h5C; wdata_in = 8'h3E; req_write = 1'b1;
        push_txn(1'b1, 8'h5C, 8'h3E, 8'h00, 12, "rst");
        tick();
        req_write = 1'b0;
        repeat (11) tick();
        #2;
        reset = 1'b0;
        #1;
        rdata_model = 8'h00;
        check("async_abort", observed(),
              pack_vec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        @(posedge clk); #1;
        reset = 1'b1;
        push_idle(1, "rst_release"); tick();
        ad_in = 8'h96; addr_in = 8'h0F; req_read = 1'b1;
        push_txn(1'b0, 8'h0F, 8'h00, 8'h96, 21, "post_rst");
        tick();
        req_read = 1'b0;
        repeat (20) tick();
        push_idle(1, "post_rst_idle"); tick();

        // Back-to-back reads: second request held through the done cycle
        ad_in = 8'h5A; addr_in = 8'h33; req_read = 1'b1;
        push_txn(1'b0, 8'h33, 8'h00, 8'h5A, 21, "b2b_a");
        tick();
        req_read = 1'b0;
        repeat (15) tick();
        gap_cnt = 0; gap_track = 1'b1;
        repeat (4) tick();
        addr_in = 8'h44; req_read = 1'b1;
        push_txn(1'b0, 8'h44, 8'h00, 8'hC3, 21, "b2b_b");
        tick();
        tick();
        gap_track = 1'b0;
        req_read = 1'b0; ad_in = 8'hC3;
        repeat (20) tick();
        check_int("b2b_recover_cycles", gap_cnt, TR);
        push_idle(2, "b2b_idle");
        tick(); tick();
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
